alu_reservation_station: RTL and testbench
==========================================

Name: alu_reservation_station

Overview:
- Issue side of the ALU path in the Tomasulo core.
- Buffers dispatched integer ops until both source operands are available, snooping the ALU and LSB result broadcasts (CDB) for the operands.
- Each cycle it issues at most one ready entry to the combinational ALU through registered op/value/imm/rob-tag outputs.
- The ALU result comes back on the ALU CDB, which this block also snoops.

Parameters:
- ENTRIES, 16: number of station slots; power of two, at least 2.
- OP_W, 6: internal opcode width. Opcode 0 is NOP.
- DATA_W, 32: operand and immediate width.
- TAG_W, 5: ROB tag width. Tag 0 means "no tag / value ready" and never matches.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- rdy  in  1  global ready; when low, the block stalls
- in_flush  in  1  misprediction clear, synchronous
- in_valid  in  1  dispatch request this cycle
- in_op  in  OP_W  dispatched opcode
- in_value1  in  DATA_W  rs1 value; meaningful only when in_tag1 is 0
- in_tag1  in  TAG_W  ROB tag producing rs1; 0 means ready
- in_value2  in  DATA_W  rs2 value
- in_tag2  in  TAG_W  ROB tag producing rs2; 0 means ready
- in_imm  in  DATA_W  immediate
- in_rob_tag  in  TAG_W  destination ROB tag
- out_full  out  1  all entries busy; combinational from the busy vector
- alu_cdb_tag  in  TAG_W  ALU broadcast tag; 0 means idle
- alu_cdb_value  in  DATA_W  ALU broadcast value
- lsb_cdb_tag  in  TAG_W  LSB broadcast tag; 0 means idle
- lsb_cdb_value  in  DATA_W  LSB broadcast value
- out_op  out  OP_W  op to ALU; NOP when nothing is issued
- out_value1  out  DATA_W  operand 1 to ALU
- out_value2  out  DATA_W  operand 2 to ALU
- out_imm  out  DATA_W  immediate to ALU
- out_rob_tag  out  TAG_W  destination tag to ALU

Behaviour:
- Per-entry state: busy, op, v1, q1, v2, q2, imm, rob_tag.
- Reset (rst low, asynchronous, takes effect immediately, including mid-operation):
  - All busy bits 0.
  - out_op = 0 (NOP); out_value1, out_value2, out_imm and out_rob_tag all 0.
  - out_full = 0.
- Priority at each clock edge, highest first: in_flush, then rdy low, then normal operation.
  - Flush: all busy bits cleared, out_* cleared as on reset, dispatch ignored.
  - rdy low: entries hold; out_op and out_rob_tag cleared to 0 so the ALU broadcast is not repeated.
- Normal edge, all actions evaluated on pre-edge state:
  - Snoop: for each busy entry, if qX != 0 and qX equals alu_cdb_tag or lsb_cdb_tag, capture that CDB value into vX and set qX to 0. If both CDBs carry the same nonzero tag, the ALU CDB wins; the values are identical by protocol.
  - Dispatch: if in_valid and not out_full, write the lowest-index non-busy entry and set busy. If in_tagX is nonzero and matches a CDB tag on that same cycle, store the CDB value and qX = 0; otherwise store in_valueX and in_tagX. in_valid while out_full is ignored: the instruction is dropped and the dispatcher must never do this.
  - Issue: select the lowest-index entry that is busy with q1 = 0 and q2 = 0 on pre-edge state. Register its fields onto out_* and clear its busy bit. If no entry is ready, out_op and out_rob_tag are 0 and the value outputs are don't-care (held at 0).
- Latency:
  - A fully ready dispatch at edge k issues at edge k+1 at the earliest.
  - An operand woken by a CDB at edge k allows issue at edge k+1.
  - The ALU result is visible on alu_cdb during the cycle after the issue edge.
- Simultaneous dispatch and issue at one edge: a slot freed by issue is not reused until the next edge, since the free index is computed pre-edge.
- Back-to-back dependency: an entry waiting on tag T issued at edge k wakes from alu_cdb at edge k+1 and issues at edge k+2.
- Tag 0 on either CDB never wakes any entry.

Test Plan:
- Reset: hold rst low mid-stream with 3 busy entries -> out_op = 0, out_full = 0 immediately; after release, no stale issue occurs.
- Ready dispatch: op ADD(3), v1 = 5, v2 = 7, tags 0, rob 4 at edge 0 -> at edge 1, out_op = 3, out_value1 = 5, out_value2 = 7, out_rob_tag = 4; out_op = 0 at edge 2.
- Wakeup: dispatch with q1 = 9, v2 = 1; at edge 3 drive lsb_cdb_tag = 9, value 0x100 -> issue at edge 4 with out_value1 = 0x100.
- Dispatch-time forwarding: in_tag2 = 6 while alu_cdb_tag = 6, value 0xAB on the same cycle -> entry issues at the next edge with out_value2 = 0xAB.
- Fill: 16 dispatches of entries with unresolved tags -> out_full = 1. A 17th in_valid is dropped. Resolving one tag issues that entry at the next edge, out_full drops after that issue edge, and a new dispatch fills the lowest free index.
- Flush and rdy: with 4 ready entries, rdy low for 2 cycles -> nothing issues and out_op = 0; then in_flush = 1 -> all entries cleared and no issue afterwards.

Source files
------------

// File: rtl/alu_reservation_station.sv
// ALU reservation station: buffers dispatched integer ops until both operands are
// available (snooping the ALU and LSB result buses) and issues at most one ready
// entry per cycle to the combinational ALU through registered outputs.
module alu_reservation_station #(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned OP_W    = 6,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TAG_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              in_flush,
    input  logic              in_valid,
    input  logic [OP_W-1:0]   in_op,
    input  logic [DATA_W-1:0] in_value1,
    input  logic [TAG_W-1:0]  in_tag1,
    input  logic [DATA_W-1:0] in_value2,
    input  logic [TAG_W-1:0]  in_tag2,
    input  logic [DATA_W-1:0] in_imm,
    input  logic [TAG_W-1:0]  in_rob_tag,
    output logic              out_full,
    input  logic [TAG_W-1:0]  alu_cdb_tag,
    input  logic [DATA_W-1:0] alu_cdb_value,
    input  logic [TAG_W-1:0]  lsb_cdb_tag,
    input  logic [DATA_W-1:0] lsb_cdb_value,
    output logic [OP_W-1:0]   out_op,
    output logic [DATA_W-1:0] out_value1,
    output logic [DATA_W-1:0] out_value2,
    output logic [DATA_W-1:0] out_imm,
    output logic [TAG_W-1:0]  out_rob_tag
);
    localparam int unsigned IdxW = $clog2(ENTRIES);

    logic [ENTRIES-1:0] busy_q, busy_d;
    logic [OP_W-1:0]    op_q   [ENTRIES];
    logic [OP_W-1:0]    op_d   [ENTRIES];
    logic [DATA_W-1:0]  v1_q   [ENTRIES];
    logic [DATA_W-1:0]  v1_d   [ENTRIES];
    logic [DATA_W-1:0]  v2_q   [ENTRIES];
    logic [DATA_W-1:0]  v2_d   [ENTRIES];
    logic [TAG_W-1:0]   q1_q   [ENTRIES];
    logic [TAG_W-1:0]   q1_d   [ENTRIES];
    logic [TAG_W-1:0]   q2_q   [ENTRIES];
    logic [TAG_W-1:0]   q2_d   [ENTRIES];
    logic [DATA_W-1:0]  imm_q  [ENTRIES];
    logic [DATA_W-1:0]  imm_d  [ENTRIES];
    logic [TAG_W-1:0]   rob_q  [ENTRIES];
    logic [TAG_W-1:0]   rob_d  [ENTRIES];

    logic [OP_W-1:0]   out_op_q, out_op_d;
    logic [DATA_W-1:0] out_v1_q, out_v1_d;
    logic [DATA_W-1:0] out_v2_q, out_v2_d;
    logic [DATA_W-1:0] out_imm_q, out_imm_d;
    logic [TAG_W-1:0]  out_rob_q, out_rob_d;

    logic            free_found, issue_found;
    logic [IdxW-1:0] free_idx, issue_idx;

    assign out_full    = &busy_q;
    assign out_op      = out_op_q;
    assign out_value1  = out_v1_q;
    assign out_value2  = out_v2_q;
    assign out_imm     = out_imm_q;
    assign out_rob_tag = out_rob_q;

    // Lowest-index free slot and lowest-index ready slot, both from pre-edge state.
    always_comb begin
        free_found  = 1'b0;
        free_idx    = '0;
        issue_found = 1'b0;
        issue_idx   = '0;
        for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                free_found = 1'b1;
                free_idx   = IdxW'(i);
            end
            if (busy_q[i] && q1_q[i] == '0 && q2_q[i] == '0) begin
                issue_found = 1'b1;
                issue_idx   = IdxW'(i);
            end
        end
    end

    // Next state: flush beats stall beats snoop/dispatch/issue.
    always_comb begin
        busy_d    = busy_q;
        op_d      = op_q;
        v1_d      = v1_q;
        v2_d      = v2_q;
        q1_d      = q1_q;
        q2_d      = q2_q;
        imm_d     = imm_q;
        rob_d     = rob_q;
        out_op_d  = out_op_q;
        out_v1_d  = out_v1_q;
        out_v2_d  = out_v2_q;
        out_imm_d = out_imm_q;
        out_rob_d = out_rob_q;
        if (in_flush) begin
            busy_d    = '0;
            out_op_d  = '0;
            out_v1_d  = '0;
            out_v2_d  = '0;
            out_imm_d = '0;
            out_rob_d = '0;
        end else if (!rdy) begin
            // Clear op/tag so the ALU does not rebroadcast the last result.
            out_op_d  = '0;
            out_rob_d = '0;
        end else begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                if (busy_q[i]) begin
                    // ALU bus checked last so it wins when both carry the same tag.
                    if (q1_q[i] != '0 && q1_q[i] == lsb_cdb_tag) begin
                        v1_d[i] = lsb_cdb_value;
                        q1_d[i] = '0;
                    end
                    if (q1_q[i] != '0 && q1_q[i] == alu_cdb_tag) begin
                        v1_d[i] = alu_cdb_value;
                        q1_d[i] = '0;
                    end
                    if (q2_q[i] != '0 && q2_q[i] == lsb_cdb_tag) begin
                        v2_d[i] = lsb_cdb_value;
                        q2_d[i] = '0;
                    end
                    if (q2_q[i] != '0 && q2_q[i] == alu_cdb_tag) begin
                        v2_d[i] = alu_cdb_value;
                        q2_d[i] = '0;
                    end
                end
            end
            if (issue_found) begin
                out_op_d          = op_q[issue_idx];
                out_v1_d          = v1_q[issue_idx];
                out_v2_d          = v2_q[issue_idx];
                out_imm_d         = imm_q[issue_idx];
                out_rob_d         = rob_q[issue_idx];
                busy_d[issue_idx] = 1'b0;
            end else begin
                out_op_d  = '0;
                out_v1_d  = '0;
                out_v2_d  = '0;
                out_imm_d = '0;
                out_rob_d = '0;
            end
            // Free slot is never the issued slot, so both writes can coexist.
            if (in_valid && free_found) begin
                busy_d[free_idx] = 1'b1;
                op_d[free_idx]   = in_op;
                imm_d[free_idx]  = in_imm;
                rob_d[free_idx]  = in_rob_tag;
                v1_d[free_idx]   = in_value1;
                q1_d[free_idx]   = in_tag1;
                v2_d[free_idx]   = in_value2;
                q2_d[free_idx]   = in_tag2;
                if (in_tag1 != '0 && in_tag1 == alu_cdb_tag) begin
                    v1_d[free_idx] = alu_cdb_value;
                    q1_d[free_idx] = '0;
                end else if (in_tag1 != '0 && in_tag1 == lsb_cdb_tag) begin
                    v1_d[free_idx] = lsb_cdb_value;
                    q1_d[free_idx] = '0;
                end
                if (in_tag2 != '0 && in_tag2 == alu_cdb_tag) begin
                    v2_d[free_idx] = alu_cdb_value;
                    q2_d[free_idx] = '0;
                end else if (in_tag2 != '0 && in_tag2 == lsb_cdb_tag) begin
                    v2_d[free_idx] = lsb_cdb_value;
                    q2_d[free_idx] = '0;
                end
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q    <= '0;
            out_op_q  <= '0;
            out_v1_q  <= '0;
            out_v2_q  <= '0;
            out_imm_q <= '0;
            out_rob_q <= '0;
            for (int i = 0; i < int'(ENTRIES); i++) begin
                op_q[i]  <= '0;
                v1_q[i]  <= '0;
                v2_q[i]  <= '0;
                q1_q[i]  <= '0;
                q2_q[i]  <= '0;
                imm_q[i] <= '0;
                rob_q[i] <= '0;
            end
        end else begin
            busy_q    <= busy_d;
            out_op_q  <= out_op_d;
            out_v1_q  <= out_v1_d;
            out_v2_q  <= out_v2_d;
            out_imm_q <= out_imm_d;
            out_rob_q <= out_rob_d;
            op_q      <= op_d;
            v1_q      <= v1_d;
            v2_q      <= v2_d;
            q1_q      <= q1_d;
            q2_q      <= q2_d;
            imm_q     <= imm_d;
            rob_q     <= rob_d;
        end
    end

endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed bench for alu_reservation_station: reset, dispatch/issue latency, wakeup,
// dispatch-time forwarding, back-to-back dependency, fill/drop, stall, flush.
module tb_alu_reservation_station;
    logic        clk, rst, rdy, in_flush, in_valid;
    logic [5:0]  in_op;
    logic [31:0] in_value1, in_value2, in_imm;
    logic [4:0]  in_tag1, in_tag2, in_rob_tag;
    logic        out_full;
    logic [4:0]  alu_cdb_tag, lsb_cdb_tag;
    logic [31:0] alu_cdb_value, lsb_cdb_value;
    logic [5:0]  out_op;
    logic [31:0] out_value1, out_value2, out_imm;
    logic [4:0]  out_rob_tag;

    int checks = 0;
    int failures = 0;

    alu_reservation_station #(
        .ENTRIES(16), .OP_W(6), .DATA_W(32), .TAG_W(5)
    ) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .in_flush(in_flush), .in_valid(in_valid),
        .in_op(in_op), .in_value1(in_value1), .in_tag1(in_tag1),
        .in_value2(in_value2), .in_tag2(in_tag2), .in_imm(in_imm),
        .in_rob_tag(in_rob_tag), .out_full(out_full),
        .alu_cdb_tag(alu_cdb_tag), .alu_cdb_value(alu_cdb_value),
        .lsb_cdb_tag(lsb_cdb_tag), .lsb_cdb_value(lsb_cdb_value),
        .out_op(out_op), .out_value1(out_value1), .out_value2(out_value2),
        .out_imm(out_imm), .out_rob_tag(out_rob_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] op, input logic [31:0] v1, input logic [4:0] t1,
                         input logic [31:0] v2, input logic [4:0] t2,
                         input logic [31:0] imm, input logic [4:0] rob);
        in_valid   = 1'b1;
        in_op      = op;
        in_value1  = v1;
        in_tag1    = t1;
        in_value2  = v2;
        in_tag2    = t2;
        in_imm     = imm;
        in_rob_tag = rob;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; in_op = '0; in_value1 = '0; in_tag1 = '0; in_value2 = '0;
        in_tag2 = '0; in_imm = '0; in_rob_tag = '0;
        alu_cdb_tag = '0; alu_cdb_value = '0; lsb_cdb_tag = '0; lsb_cdb_value = '0;
    endtask

    task automatic test_reset();
        rst = 1'b0; rdy = 1'b1; in_flush = 1'b0;
        idle_inputs();
        #3;
        checks++;
        if (out_op !== 6'd0) begin
            failures++; $display("FAIL reset_op got=%0h exp=0", out_op);
        end
        checks++;
        if (out_full !== 1'b0) begin
            failures++; $display("FAIL reset_full got=%0b exp=0", out_full);
        end
        checks++;
        if (out_value1 !== 32'd0 || out_rob_tag !== 5'd0) begin
            failures++;
            $display("FAIL reset_vals got v1=%0h rob=%0h exp=0", out_value1, out_rob_tag);
        end
        step(); step();
        #3 rst = 1'b1;
        step();
        checks++;
        if (out_op !== 6'd0) begin
            failures++; $display("FAIL post_reset_op got=%0h exp=0", out_op);
        end
    endtask

    task automatic test_ready_dispatch();
        drive(6'd3, 32'd5, 5'd0, 32'd7, 5'd0, 32'h11, 5'd4);
        step();
        idle_inputs();
        checks++;
        if (out_op !== 6'd0) begin
            failures++; $display("FAIL rd_early_op got=%0h exp=0", out_op);
        end
        step();
        checks++;
        if (out_op !== 6'd3 || out_value1 !== 32'd5 || out_value2 !== 32'd7 ||
            out_imm !== 32'h11 || out_rob_tag !== 5'd4) begin
            failures++;
            $display("FAIL rd_issue got op=%0h v1=%0h v2=%0h imm=%0h rob=%0h exp 3/5/7/11/4",
                     out_op, out_value1, out_value2, out_imm, out_rob_tag);
        end
        step();
        checks++;
        if (out_op !== 6'd0 || out_rob_tag !== 5'd0) begin
            failures++; $display("FAIL rd_after got op=%0h rob=%0h exp=0", out_op, out_rob_tag);
        end
    endtask

    task automatic test_wakeup();
        drive(6'd4, 32'hFFFF, 5'd9, 32'd1, 5'd0, 32'd0, 5'd5);
        step();
        idle_inputs();
        // Tag 0 on the buses with junk values must not touch any operand.
        alu_cdb_value = 32'hDEAD; lsb_cdb_value = 32'hBEEF;
        step(); step();
        checks++;
        if (out_op !== 6'd0) begin
            failures++; $display("FAIL wk_wait_op got=%0h exp=0", out_op);
        end
        lsb_cdb_tag = 5'd9; lsb_cdb_value = 32'h100;
        step();
        idle_inputs();
        checks++;
        if (out_op !== 6'd0) begin
            failures++; $display("FAIL wk_wake_op got=%0h exp=0", out_op);
        end
        step();
        checks++;
        if (out_op !== 6'd4 || out_value1 !== 32'h100 || out_value2 !== 32'd1 ||
            out_rob_tag !== 5'd5) begin
            failures++;
            $display("FAIL wk_issue got op=%0h v1=%0h v2=%0h rob=%0h exp 4/100/1/5",
                     out_op, out_value1, out_value2, out_rob_tag);
        end
    endtask

    task automatic test_forward();
        drive(6'd5, 32'd2, 5'd0, 32'h55, 5'd6, 32'd0, 5'd7);
        alu_cdb_tag = 5'd6; alu_cdb_value = 32'hAB;
        step();
        idle_inputs();
        step();
        checks++;
        if (out_op !== 6'd5 || out_value1 !== 32'd2 || out_value2 !== 32'hAB ||
            out_rob_tag !== 5'd7) begin
            failures++;
            $display("FAIL fwd_issue got op=%0h v1=%0h v2=%0h rob=%0h exp 5/2/ab/7",
                     out_op, out_value1, out_value2, out_rob_tag);
        end
    endtask

    task automatic test_back_to_back();
        drive(6'd1, 32'd10, 5'd0, 32'd20, 5'd0, 32'd0, 5'd3);
        step();
        drive(6'd2, 32'd0, 5'd3, 32'd4, 5'd0, 32'd0, 5'd8);
        step();
        idle_inputs();
        checks++;
        if (out_op !== 6'd1 || out_rob_tag !== 5'd3) begin
            failures++; $display("FAIL b2b_first got op=%0h rob=%0h exp 1/3", out_op, out_rob_tag);
        end
        // Stand in for the ALU broadcasting the result the cycle after issue.
        alu_cdb_tag = 5'd3; alu_cdb_value = 32'd30;
        step();
        idle_inputs();
        checks++;
        if (out_op !== 6'd0) begin
            failures++; $display("FAIL b2b_gap got=%0h exp=0", out_op);
        end
        step();
        checks++;
        if (out_op !== 6'd2 || out_value1 !== 32'd30 || out_value2 !== 32'd4 ||
            out_rob_tag !== 5'd8) begin
            failures++;
            $display("FAIL b2b_second got op=%0h v1=%0h v2=%0h rob=%0h exp 2/1e/4/8",
                     out_op, out_value1, out_value2, out_rob_tag);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            drive(6'd8, 32'd0, 5'(16 + i), 32'(i), 5'd0, 32'd0, 5'(i + 1));
            step();
        end
        idle_inputs();
        checks++;
        if (out_full !== 1'b1 || out_op !== 6'd0) begin
            failures++; $display("FAIL fill_full got full=%0b op=%0h exp 1/0", out_full, out_op);
        end
        drive(6'd9, 32'd1, 5'd0, 32'd1, 5'd0, 32'd0, 5'd31);
        step();
        idle_inputs();
        step();
        checks++;
        if (out_full !== 1'b1 || out_op !== 6'd0) begin
            failures++; $display("FAIL fill_drop got full=%0b op=%0h exp 1/0", out_full, out_op);
        end
        alu_cdb_tag = 5'd21; alu_cdb_value = 32'h500;
        step();
        idle_inputs();
        checks++;
        if (out_full !== 1'b1 || out_op !== 6'd0) begin
            failures++; $display("FAIL fill_wake got full=%0b op=%0h exp 1/0", out_full, out_op);
        end
        step();
        checks++;
        if (out_op !== 6'd8 || out_rob_tag !== 5'd6 || out_value1 !== 32'h500 ||
            out_value2 !== 32'd5 || out_full !== 1'b0) begin
            failures++;
            $display("FAIL fill_issue got op=%0h rob=%0h v1=%0h v2=%0h full=%0b exp 8/6/500/5/0",
                     out_op, out_rob_tag, out_value1, out_value2, out_full);
        end
        drive(6'd10, 32'd1, 5'd0, 32'd2, 5'd0, 32'd0, 5'd20);
        step();
        idle_inputs();
        checks++;
        if (out_full !== 1'b1) begin
            failures++; $display("FAIL fill_refill got full=%0b exp=1", out_full);
        end
        // Asynchronous reset mid-cycle with every slot busy.
        #2 rst = 1'b0;
        #1;
        checks++;
        if (out_full !== 1'b0 || out_op !== 6'd0) begin
            failures++;
            $display("FAIL fill_async_rst got full=%0b op=%0h exp 0/0", out_full, out_op);
        end
        #2 rst = 1'b1;
        alu_cdb_tag = 5'd16; alu_cdb_value = 32'd1;
        step();
        idle_inputs();
        step();
        checks++;
        if (out_op !== 6'd0 || out_full !== 1'b0) begin
            failures++;
            $display("FAIL fill_no_stale got op=%0h full=%0b exp 0/0", out_op, out_full);
        end
    endtask

    task automatic test_flush_rdy();
        for (int i = 0; i < 4; i++) begin
            drive(6'(11 + i), 32'd0, 5'd12, 32'(i), 5'd0, 32'd0, 5'(i + 1));
            step();
        end
        idle_inputs();
        alu_cdb_tag = 5'd12; alu_cdb_value = 32'h77;
        step();
        idle_inputs();
        step();
        checks++;
        if (out_op !== 6'd11 || out_rob_tag !== 5'd1 || out_value1 !== 32'h77) begin
            failures++;
            $display("FAIL fr_issue got op=%0h rob=%0h v1=%0h exp b/1/77",
                     out_op, out_rob_tag, out_value1);
        end
        rdy = 1'b0;
        for (int c = 0; c < 2; c++) begin
            step();
            checks++;
            if (out_op !== 6'd0 || out_rob_tag !== 5'd0) begin
                failures++;
                $display("FAIL fr_stall%0d got op=%0h rob=%0h exp 0/0", c, out_op, out_rob_tag);
            end
        end
        rdy = 1'b1; in_flush = 1'b1;
        step();
        in_flush = 1'b0;
        checks++;
        if (out_op !== 6'd0 || out_full !== 1'b0 || out_value1 !== 32'd0) begin
            failures++;
            $display("FAIL fr_flush got op=%0h full=%0b v1=%0h exp 0/0/0",
                     out_op, out_full, out_value1);
        end
        for (int c = 0; c < 2; c++) begin
            step();
            checks++;
            if (out_op !== 6'd0) begin
                failures++; $display("FAIL fr_after%0d got op=%0h exp=0", c, out_op);
            end
        end
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 3; i++) begin
            drive(6'd1, 32'd0, 5'(20 + i), 32'd0, 5'd0, 32'd0, 5'(i + 1));
            step();
        end
        drive(6'd7, 32'h33, 5'd0, 32'd0, 5'd0, 32'd0, 5'd9);
        step();
        idle_inputs();
        step();
        checks++;
        if (out_op !== 6'd7 || out_value1 !== 32'h33) begin
            failures++; $display("FAIL ms_issue got op=%0h v1=%0h exp 7/33", out_op, out_value1);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (out_op !== 6'd0 || out_rob_tag !== 5'd0 || out_value1 !== 32'd0 ||
            out_full !== 1'b0) begin
            failures++;
            $display("FAIL ms_async_rst got op=%0h rob=%0h v1=%0h full=%0b exp 0",
                     out_op, out_rob_tag, out_value1, out_full);
        end
        #2 rst = 1'b1;
        alu_cdb_tag = 5'd20; alu_cdb_value = 32'd1;
        lsb_cdb_tag = 5'd21; lsb_cdb_value = 32'd2;
        step();
        idle_inputs();
        for (int c = 0; c < 2; c++) begin
            step();
            checks++;
            if (out_op !== 6'd0) begin
                failures++; $display("FAIL ms_no_stale%0d got op=%0h exp=0", c, out_op);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ready_dispatch();
        test_wakeup();
        test_forward();
        test_back_to_back();
        test_fill();
        test_flush_rdy();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
